// File: rtl/counter_pkg.sv
// Shared definitions for the bounded step counter: mode encodings and direction values.
package counter_pkg;

    localparam logic [1:0] MODE_WRAP   = 2'b00;
    localparam logic [1:0] MODE_SAT    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-state for the bounded step counter: one enabled step
// in wrap, saturate or bounce mode, with a flag when a bound is hit.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MIN   = 10,
    parameter int MAX   = 40,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_count,
    output logic             next_dir,
    output logic             bound_evt
);

    localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN);
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);

    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] dn_diff;
    logic           dn_under;
    logic           hit_hi_sat;
    logic           hit_lo_sat;

    // One extra bit keeps overflow past 2**WIDTH-1 and borrow below zero visible.
    assign up_sum     = {1'b0, count} + STEP_X;
    assign dn_diff    = {1'b0, count} - STEP_X;
    assign dn_under   = dn_diff[WIDTH];
    assign hit_hi_sat = (up_sum >= MAX_X);
    assign hit_lo_sat = dn_under || (dn_diff <= MIN_X);

    always_comb begin
        next_count = count;
        next_dir   = dir;
        bound_evt  = 1'b0;
        case (mode)
            MODE_SAT: begin
                if (dir == DIR_UP) begin
                    next_count = hit_hi_sat ? MAX_W : up_sum[WIDTH-1:0];
                    bound_evt  = hit_hi_sat;
                end else begin
                    next_count = hit_lo_sat ? MIN_W : dn_diff[WIDTH-1:0];
                    bound_evt  = hit_lo_sat;
                end
            end
            MODE_BOUNCE: begin
                if (dir == DIR_UP) begin
                    next_count = hit_hi_sat ? MAX_W : up_sum[WIDTH-1:0];
                    next_dir   = hit_hi_sat ? DIR_DN : DIR_UP;
                    bound_evt  = hit_hi_sat;
                end else begin
                    next_count = hit_lo_sat ? MIN_W : dn_diff[WIDTH-1:0];
                    next_dir   = hit_lo_sat ? DIR_UP : DIR_DN;
                    bound_evt  = hit_lo_sat;
                end
            end
            default: begin
                if (dir == DIR_UP) begin
                    bound_evt  = (up_sum > MAX_X);
                    next_count = bound_evt ? MIN_W : up_sum[WIDTH-1:0];
                end else begin
                    bound_evt  = dn_under || (dn_diff < MIN_X);
                    next_count = bound_evt ? MAX_W : dn_diff[WIDTH-1:0];
                end
            end
        endcase
    end

endmodule

// File: rtl/bounded_step_counter.sv
// Bounded up/down counter with wrap/saturate/bounce modes, load and terminal-count pulse.
// Define BOUNDED_STEP_COUNTER_LOAD_CLAMP_EN to clamp out-of-range loads to the nearest bound.
module bounded_step_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MIN   = 10,
    parameter int MAX   = 40,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             u_d,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    logic             dir_eff;
    logic [WIDTH-1:0] next_count;
    logic             next_dir;
    logic             bound_evt;
    logic             data_ok;

    // Bounce follows its own direction register; the other modes follow u_d.
    assign dir_eff = (mode == MODE_BOUNCE) ? dir : u_d;
    assign data_ok = (int'(data) >= MIN) && (int'(data) <= MAX);

    counter_next_calc #(
        .WIDTH (WIDTH),
        .MIN   (MIN),
        .MAX   (MAX),
        .STEP  (STEP)
    ) u_next (
        .count      (count),
        .dir        (dir_eff),
        .mode       (mode),
        .next_count (next_count),
        .next_dir   (next_dir),
        .bound_evt  (bound_evt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= MIN_W;
            dir      <= DIR_UP;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            tc <= 1'b0;
            if (data_ok) begin
                count    <= data;
                load_err <= 1'b0;
            end else begin
                load_err <= 1'b1;
`ifdef BOUNDED_STEP_COUNTER_LOAD_CLAMP_EN
                count    <= (int'(data) < MIN) ? MIN_W : MAX_W;
`else
                count    <= MIN_W;
`endif
            end
        end else if (en) begin
            count    <= next_count;
            dir      <= next_dir;
            tc       <= bound_evt;
            load_err <= 1'b0;
        end else begin
            tc       <= 1'b0;
            load_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bounded_step_counter.sv
// Bench for bounded_step_counter: four parameter sets share one stimulus stream
// and are compared every cycle against an integer model, plus literal spot checks.
module tb_bounded_step_counter;
    import counter_pkg::*;

    localparam int N = 4;
    localparam int LO[N] = '{10, 10, 0, 20};
    localparam int HI[N] = '{40, 40, 40, 20};
    localparam int ST[N] = '{1, 7, 3, 1};

    typedef struct {
        int cnt;
        bit dir;
        bit tc;
        bit lerr;
    } mstate_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] data;
    logic       u_d;
    logic [1:0] mode;

    logic [7:0] dut_count [N];
    logic       dut_dir   [N];
    logic       dut_tc    [N];
    logic       dut_lerr  [N];

    mstate_t m [N];

    int  checks;
    int  failures;
    bit  done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        bounded_step_counter #(
            .WIDTH (8),
            .MIN   (LO[g]),
            .MAX   (HI[g]),
            .STEP  (ST[g])
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .load     (load),
            .data     (data),
            .u_d      (u_d),
            .mode     (mode),
            .count    (dut_count[g]),
            .dir      (dut_dir[g]),
            .tc       (dut_tc[g]),
            .load_err (dut_lerr[g])
        );
    end

    // Integer-level reading of the counter rules, one call per clock edge.
    function automatic mstate_t modelNext(mstate_t s, int lo, int hi, int stp,
                                          bit ld, bit e, int d, bit ud, bit [1:0] md);
        mstate_t n;
        bit      up;
        int      t;
        n      = s;
        n.tc   = 1'b0;
        n.lerr = 1'b0;
        if (ld) begin
            if (d >= lo && d <= hi) begin
                n.cnt = d;
            end else begin
                n.lerr = 1'b1;
`ifdef BOUNDED_STEP_COUNTER_LOAD_CLAMP_EN
                n.cnt = (d < lo) ? lo : hi;
`else
                n.cnt = lo;
`endif
            end
        end else if (e) begin
            if (md == 2'b10) begin
                up = s.dir;
            end else begin
                up    = ud;
                n.dir = ud;
            end
            t = up ? s.cnt + stp : s.cnt - stp;
            if (md == 2'b10) begin
                if (up && t >= hi) begin
                    n.cnt = hi; n.dir = 1'b0; n.tc = 1'b1;
                end else if (!up && t <= lo) begin
                    n.cnt = lo; n.dir = 1'b1; n.tc = 1'b1;
                end else begin
                    n.cnt = t;
                end
            end else if (md == 2'b01) begin
                if (up && t >= hi) begin
                    n.cnt = hi; n.tc = 1'b1;
                end else if (!up && t <= lo) begin
                    n.cnt = lo; n.tc = 1'b1;
                end else begin
                    n.cnt = t;
                end
            end else begin
                if (t > hi) begin
                    n.cnt = lo; n.tc = 1'b1;
                end else if (t < lo) begin
                    n.cnt = hi; n.tc = 1'b1;
                end else begin
                    n.cnt = t;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m[i] <= '{cnt: LO[i], dir: 1'b1, tc: 1'b0, lerr: 1'b0};
            end else begin
                m[i] <= modelNext(m[i], LO[i], HI[i], ST[i], load, en, int'(data), u_d, mode);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit ld, input bit e, input int d, input bit ud,
                                 input logic [1:0] md);
        load = ld;
        en   = e;
        data = 8'(d);
        u_d  = ud;
        mode = md;
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison of every instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                for (int i = 0; i < N; i++) begin
                    checkOutput($sformatf("model_count[%0d]", i), int'(dut_count[i]), m[i].cnt);
                    checkOutput($sformatf("model_dir[%0d]", i), int'(dut_dir[i]), int'(m[i].dir));
                    checkOutput($sformatf("model_tc[%0d]", i), int'(dut_tc[i]), int'(m[i].tc));
                    checkOutput($sformatf("model_lerr[%0d]", i), int'(dut_lerr[i]), int'(m[i].lerr));
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        done     = 1'b0;
        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        data = 8'd0;
        u_d  = 1'b1;
        mode = MODE_WRAP;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_count", int'(dut_count[0]), 10);
        checkOutput("reset_dir", int'(dut_dir[0]), 1);
        checkOutput("reset_tc", int'(dut_tc[0]), 0);
        checkOutput("reset_lerr", int'(dut_lerr[0]), 0);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) applyStimulus(0, 1, 0, 1, MODE_WRAP);
        checkOutput("wrap_top", int'(dut_count[0]), 40);
        checkOutput("wrap_top_tc", int'(dut_tc[0]), 0);
        applyStimulus(0, 1, 0, 1, MODE_WRAP);
        checkOutput("wrap_rollover", int'(dut_count[0]), 10);
        checkOutput("wrap_rollover_tc", int'(dut_tc[0]), 1);
        checkOutput("degen_wrap_tc", int'(dut_tc[3]), 1);
        applyStimulus(0, 0, 0, 1, MODE_WRAP);
        checkOutput("hold_tc", int'(dut_tc[0]), 0);

        applyStimulus(1, 0, 38, 1, MODE_SAT);
        applyStimulus(0, 1, 0, 1, MODE_SAT);
        checkOutput("sat_39", int'(dut_count[0]), 39);
        checkOutput("sat_39_tc", int'(dut_tc[0]), 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 1, MODE_SAT);
            checkOutput("sat_pinned", int'(dut_count[0]), 40);
            checkOutput("sat_pinned_tc", int'(dut_tc[0]), 1);
        end

        applyStimulus(1, 0, 38, 1, MODE_BOUNCE);
        applyStimulus(0, 1, 0, 0, MODE_BOUNCE);
        checkOutput("bounce_39", int'(dut_count[0]), 39);
        checkOutput("bounce_39_dir", int'(dut_dir[0]), 1);
        applyStimulus(0, 1, 0, 0, MODE_BOUNCE);
        checkOutput("bounce_40", int'(dut_count[0]), 40);
        checkOutput("bounce_40_dir", int'(dut_dir[0]), 0);
        checkOutput("bounce_40_tc", int'(dut_tc[0]), 1);
        applyStimulus(0, 1, 0, 0, MODE_BOUNCE);
        checkOutput("bounce_back_39", int'(dut_count[0]), 39);
        checkOutput("bounce_back_tc", int'(dut_tc[0]), 0);
        applyStimulus(0, 1, 0, 0, MODE_BOUNCE);
        checkOutput("bounce_back_38", int'(dut_count[0]), 38);

        applyStimulus(1, 1, 25, 1, MODE_WRAP);
        checkOutput("load_over_en", int'(dut_count[0]), 25);
        checkOutput("load_ok_lerr", int'(dut_lerr[0]), 0);
        applyStimulus(1, 0, 50, 1, MODE_WRAP);
`ifdef BOUNDED_STEP_COUNTER_LOAD_CLAMP_EN
        checkOutput("load_bad_count", int'(dut_count[0]), 40);
`else
        checkOutput("load_bad_count", int'(dut_count[0]), 10);
`endif
        checkOutput("load_bad_lerr", int'(dut_lerr[0]), 1);
        applyStimulus(0, 0, 0, 1, MODE_WRAP);
        checkOutput("lerr_pulse_end", int'(dut_lerr[0]), 0);

        applyStimulus(1, 0, 38, 1, MODE_WRAP);
        applyStimulus(0, 1, 0, 1, MODE_WRAP);
        checkOutput("step7_up_wrap", int'(dut_count[1]), 10);
        checkOutput("step7_up_tc", int'(dut_tc[1]), 1);
        applyStimulus(1, 0, 12, 0, MODE_WRAP);
        applyStimulus(0, 1, 0, 0, MODE_WRAP);
        checkOutput("step7_dn_wrap", int'(dut_count[1]), 40);
        checkOutput("step7_dn_tc", int'(dut_tc[1]), 1);
        applyStimulus(1, 0, 1, 0, MODE_WRAP);
        applyStimulus(0, 1, 0, 0, MODE_WRAP);
        checkOutput("min0_underflow", int'(dut_count[2]), 40);
        checkOutput("min0_underflow_tc", int'(dut_tc[2]), 1);

        applyStimulus(1, 0, 20, 1, MODE_WRAP);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 1, MODE_WRAP);
        checkOutput("pre_reset_27", int'(dut_count[0]), 27);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_count", int'(dut_count[0]), 10);
        checkOutput("async_rst_tc", int'(dut_tc[0]), 0);
        checkOutput("async_rst_lerr", int'(dut_lerr[0]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0, 1, 0, 1, MODE_WRAP);
        checkOutput("post_reset_first", int'(dut_count[0]), 11);
        applyStimulus(0, 0, 0, 1, MODE_WRAP);

        @(negedge clk);
        #1;
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bounded_step_counter.md
Name: bounded_step_counter

Overview:
- Parametrised successor to the team's fixed-range 10-to-40 up/down counter.
- Adds configurable width, bounds and step size, plus run-time selectable wrap, saturate and bounce modes.
- Adds a count enable, a registered terminal-count pulse and a load-range error flag.
- Used as a general sequencer/timebase counter in control datapaths.

Parameters:
- WIDTH, 8, counter width in bits.
- MIN, 10, lower bound (inclusive).
- MAX, 40, upper bound (inclusive). Constraint: MIN <= MAX < 2**WIDTH.
- STEP, 1, increment/decrement per enabled cycle. Constraint: 1 <= STEP <= max(1, MAX-MIN).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  count enable.
- load  in  1  synchronous load request.
- data  in  WIDTH  load value.
- u_d  in  1  direction: 1 = up, 0 = down. Used in wrap and saturate modes only.
- mode  in  2  00 wrap, 01 saturate, 10 bounce, 11 reserved (behaves as wrap).
- count  out  WIDTH  current count (registered).
- dir  out  1  registered effective direction (1 = up).
- tc  out  1  terminal-count pulse, one cycle.
- load_err  out  1  pulse, one cycle: last load value was out of range.

Behaviour:
- Reset (asynchronous, active-high): count=MIN, dir=1, tc=0, load_err=0.
- Priority per clock edge: load > en > hold.
- Load:
  - If MIN <= data <= MAX: count <= data, load_err <= 0.
  - Otherwise: count <= MIN, load_err <= 1.
  - dir is unchanged by load; tc <= 0.
- Hold (en=0, load=0): count and dir unchanged, tc <= 0, load_err <= 0.
- Arithmetic: evaluate count+STEP and count-STEP in WIDTH+1 bits so values past 2**WIDTH-1 or below 0 are detected, never silently truncated.
- Wrap mode (en=1, u_d used):
  - Up: if count+STEP > MAX, count <= MIN and tc <= 1; else count <= count+STEP.
  - Down: if count-STEP < MIN (including underflow), count <= MAX and tc <= 1; else count <= count-STEP.
- Saturate mode:
  - Up: if count+STEP >= MAX, count <= MAX and tc <= 1.
  - Down: if count-STEP <= MIN, count <= MIN and tc <= 1.
  - tc therefore repeats each enabled cycle while pinned at a bound.
- Bounce mode (u_d ignored; internal direction register dir_q):
  - dir_q=1 and count+STEP >= MAX: count <= MAX, dir_q <= 0, tc <= 1.
  - dir_q=0 and count-STEP <= MIN: count <= MIN, dir_q <= 1, tc <= 1.
  - Otherwise step in direction dir_q.
- dir_q update rule: in wrap/saturate modes dir_q <= u_d every cycle. Entering bounce starts from the last sampled u_d.
- Degenerate MIN == MAX: count stays at MIN. Every enabled cycle asserts tc. dir toggles in bounce mode.
- mode and u_d changes take effect on the next enabled step; no glitch or extra tc.
- Reset asserted mid-count returns all outputs to reset values immediately. The first enabled edge after release counts from MIN.
- The counter never leaves [MIN, MAX].

Optional Feature:
- Macro: BOUNDED_STEP_COUNTER_LOAD_CLAMP_EN.
- Defined: an out-of-range load clamps to the nearest bound (data < MIN gives MIN, data > MAX gives MAX). load_err still pulses.
- Undefined: an out-of-range load forces MIN, as described above.

Decomposition:
- Shared package counter_pkg holds:
  - mode localparams MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_BOUNCE=2'b10;
  - DIR_UP=1'b1, DIR_DN=1'b0.
- Sub-module counter_next_calc (purely combinational):
  - inputs: count, dir, mode;
  - outputs: next count, next dir, bound-event flag.
- Top level holds the registers and the load/enable priority logic.

Test Plan (defaults WIDTH=8, MIN=10, MAX=40, STEP=1 unless stated):
- Reset, then en=1, u_d=1, mode=wrap for 31 cycles -> count 10..40, then 10; tc high exactly one cycle after the 40->10 transition.
- mode=sat, load 38, u_d=1, en=1 -> count 39, 40, 40, 40; tc=1 on each cycle pinned at 40.
- mode=bounce, load 38, en=1 -> count 39, 40, 39, 38; dir goes 1 -> 0 together with count=40; tc pulses once.
- load=1 and en=1 in the same cycle with data=25 -> count=25, no step. Then load data=50 -> count=10 and load_err=1 (with macro: count=40).
- STEP=7, mode=wrap, load 38, up -> count 10 and tc. Then down from 12 -> count 40 and tc. No WIDTH underflow artefact (WIDTH=8, MIN=0, STEP=3 from 1 down -> MAX).
- rst asserted asynchronously mid-count at count=27 -> count=10, tc=0, load_err=0 before the next clock edge.
